seq_detect_scheduler: RTL and testbench

Time-shares one programmable serial pattern-detect engine among NREQ requesters. Each requester presents a parallel frame word. The scheduler grants requesters round-robin, serialises the granted frame MSB-first into the detector (one bit per clock), and counts overlapping pattern matches. At frame end it returns the match count with a one-cycle done pulse. It sits between the frame producers and the detect datapath and also owns the detector's pattern configuration.

---
 rtl/seq_detect_scheduler.sv | 164 ++++++++++++++++
 tb/tb_seq_detect_scheduler.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_scheduler.sv
// Round-robin scheduler that time-shares one serial pattern detector among NREQ requesters.
// The granted frame is shifted out MSB-first, one bit per clock. Overlapping matches are
// counted, and the count is returned with a one-cycle done pulse when the frame ends.
module seq_detect_scheduler #(
  parameter int unsigned       NREQ      = 4,
  parameter int unsigned       FRAME_W   = 8,
  parameter int unsigned       PAT_W     = 4,
  parameter logic [PAT_W-1:0]  PAT_RESET = 4'b0110,
  parameter int unsigned       CNT_W     = 4,
  parameter int unsigned       ID_W      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*FRAME_W-1:0]  frame_data,
  input  logic                     cfg_we,
  input  logic [PAT_W-1:0]         cfg_pat,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     ser_valid,
  output logic                     ser_bit,
  output logic                     done,
  output logic [ID_W-1:0]          done_id,
  output logic [CNT_W-1:0]         match_cnt,
  output logic                     cfg_err
);

  localparam int unsigned BcntW = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     win_q, win_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [FRAME_W-1:0]  shreg_q, shreg_d;
  logic [PAT_W-2:0]    hist_q, hist_d;
  logic [BcntW-1:0]    bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PAT_W-1:0]    pat_q, pat_d;
  logic                done_q, done_d;
  logic [ID_W-1:0]     done_id_q, done_id_d;
  logic [CNT_W-1:0]    match_cnt_q, match_cnt_d;
  logic                cfg_err_q, cfg_err_d;

  logic                arb_found;
  logic [ID_W-1:0]     arb_idx;
  int unsigned         arb_scan;
  logic [PAT_W-1:0]    window;
  logic                match_now;
  logic [CNT_W-1:0]    cnt_next;

  assign ser_bit   = shreg_q[FRAME_W-1];
  assign busy      = (state_q == StShift);
  assign ser_valid = busy;
  assign gnt       = gnt_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign match_cnt = match_cnt_q;
  assign cfg_err   = cfg_err_q;

  // Detector window: the last PAT_W-1 bits seen plus the bit on the wire now.
  assign window    = {hist_q, ser_bit};
  // History is cleared per frame, so only full windows inside the frame may match.
  assign match_now = (bitcnt_q >= BcntW'(PAT_W - 1)) && (window == pat_q);
  assign cnt_next  = (match_now && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  // Round-robin pick: first asserted request at or after the pointer, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    arb_scan  = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      arb_scan = (32'(ptr_q) + i) % NREQ;
      if (!arb_found && req[arb_scan]) begin
        arb_found = 1'b1;
        arb_idx   = ID_W'(arb_scan);
      end
    end
  end

  // Next-state logic for the grant/shift FSM, detector datapath and config register.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    gnt_d       = gnt_q;
    shreg_d     = shreg_q;
    hist_d      = hist_q;
    bitcnt_d    = bitcnt_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    done_d      = 1'b0;
    done_id_d   = done_id_q;
    match_cnt_d = match_cnt_q;
    cfg_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A pattern written on the grant edge already applies to that frame.
        if (cfg_we) pat_d = cfg_pat;
        if (arb_found) begin
          win_d    = arb_idx;
          gnt_d    = NREQ'(1) << arb_idx;
          shreg_d  = frame_data[32'(arb_idx) * FRAME_W +: FRAME_W];
          hist_d   = '0;
          bitcnt_d = '0;
          cnt_d    = '0;
          ptr_d    = (arb_idx == ID_W'(NREQ - 1)) ? '0 : arb_idx + ID_W'(1);
          state_d  = StShift;
        end
      end
      StShift: begin
        if (cfg_we) cfg_err_d = 1'b1;
        hist_d   = window[PAT_W-2:0];
        shreg_d  = {shreg_q[FRAME_W-2:0], 1'b0};
        bitcnt_d = bitcnt_q + BcntW'(1);
        cnt_d    = cnt_next;
        if (bitcnt_q == BcntW'(FRAME_W - 1)) begin
          done_d      = 1'b1;
          done_id_d   = win_q;
          match_cnt_d = cnt_next;
          gnt_d       = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers; reset aborts any frame in flight without a done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      win_q       <= '0;
      gnt_q       <= '0;
      shreg_q     <= '0;
      hist_q      <= '0;
      bitcnt_q    <= '0;
      cnt_q       <= '0;
      pat_q       <= PAT_RESET;
      done_q      <= 1'b0;
      done_id_q   <= '0;
      match_cnt_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      shreg_q     <= shreg_d;
      hist_q      <= hist_d;
      bitcnt_q    <= bitcnt_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      done_q      <= done_d;
      done_id_q   <= done_id_d;
      match_cnt_q <= match_cnt_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed bench for seq_detect_scheduler: a vector table of single frames plus hand-written
// sequences for round-robin, config rejection and mid-frame reset.
module tb_seq_detect_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] frame_data;
  logic        cfg_we;
  logic [3:0]  cfg_pat;
  logic [3:0]  gnt;
  logic        busy;
  logic        ser_valid;
  logic        ser_bit;
  logic        done;
  logic [1:0]  done_id;
  logic [3:0]  match_cnt;
  logic        cfg_err;

  int checks = 0;
  int errors = 0;

  seq_detect_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .frame_data (frame_data),
    .cfg_we     (cfg_we),
    .cfg_pat    (cfg_pat),
    .gnt        (gnt),
    .busy       (busy),
    .ser_valid  (ser_valid),
    .ser_bit    (ser_bit),
    .done       (done),
    .done_id    (done_id),
    .match_cnt  (match_cnt),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] fd;
    logic        cw;
    logic [3:0]  cp;
    logic [3:0]  eg;
    logic [7:0]  es;
    logic [1:0]  eid;
    logic [3:0]  ecnt;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge while idle (or in the done cycle); runs one full frame.
  task automatic run_frame(input logic [3:0] r, input logic [31:0] fd, input logic cw,
                           input logic [3:0] cp, input logic [3:0] eg, input logic [7:0] es,
                           input logic [1:0] eid, input logic [3:0] ecnt, input bit hold);
    logic [7:0] got;
    req        = r;
    frame_data = fd;
    cfg_we     = cw;
    cfg_pat    = cp;
    @(negedge clk);
    cfg_we = 1'b0;
    if (!hold) req = 4'b0000;
    check("gnt", 32'(gnt), 32'(eg));
    check("busy_in_frame", 32'(busy), 32'd1);
    check("ser_valid", 32'(ser_valid), 32'd1);
    check("done_low_at_grant", 32'(done), 32'd0);
    check("cfg_err_low", 32'(cfg_err), 32'd0);
    got[7] = ser_bit;
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      got[7-k] = ser_bit;
    end
    check("ser_seq", 32'(got), 32'(es));
    @(negedge clk);
    check("done", 32'(done), 32'd1);
    check("done_id", 32'(done_id), 32'(eid));
    check("match_cnt", 32'(match_cnt), 32'(ecnt));
    check("gnt_after_done", 32'(gnt), 32'd0);
    check("busy_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{4'b0001, 32'h0000_0036, 1'b0, 4'b0000, 4'b0001, 8'h36, 2'd0, 4'd2};
    vecs[1] = '{4'b0010, 32'h0000_6C00, 1'b0, 4'b0000, 4'b0010, 8'h6C, 2'd1, 4'd2};
    vecs[2] = '{4'b0100, 32'hFF00_FFFF, 1'b1, 4'b0000, 4'b0100, 8'h00, 2'd2, 4'd5};
    vecs[3] = '{4'b1000, 32'hB600_0000, 1'b1, 4'b1011, 4'b1000, 8'hB6, 2'd3, 4'd2};
    vecs[4] = '{4'b0110, 32'h00FF_3600, 1'b1, 4'b0110, 4'b0010, 8'h36, 2'd1, 4'd2};
    vecs[5] = '{4'b0011, 32'h0000_36FF, 1'b0, 4'b0000, 4'b0001, 8'hFF, 2'd0, 4'd0};

    rst        = 1'b0;
    req        = 4'b0000;
    frame_data = 32'h0;
    cfg_we     = 1'b0;
    cfg_pat    = 4'b0000;

    // Reset state.
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ser_bit", 32'(ser_bit), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_match_cnt", 32'(match_cnt), 32'd0);
    check("rst_cfg_err", 32'(cfg_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_req_busy", 32'(busy), 32'd0);
    check("idle_no_req_gnt", 32'(gnt), 32'd0);

    // Single frames from the table (back-to-back, pointer carries across vectors).
    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].req, vecs[v].fd, vecs[v].cw, vecs[v].cp, vecs[v].eg, vecs[v].es,
                vecs[v].eid, vecs[v].ecnt, 1'b0);
    end

    // Load 1011 so the post-reset frame shows the pattern came back to 0110.
    cfg_we  = 1'b1;
    cfg_pat = 4'b1011;
    @(negedge clk);
    cfg_we = 1'b0;

    // Mid-frame reset: pointer is 1 here, so requester 2 wins.
    req        = 4'b0100;
    frame_data = 32'h0036_0000;
    @(negedge clk);
    req = 4'b0000;
    check("mid_gnt", 32'(gnt), 32'b0100);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    check("mid_rst_done_hold", 32'(done), 32'd0);
    rst = 1'b1;

    // Held req=1111 after reset: 0,1,2,3,0 one per 9 cycles, then 1010 -> 1,3,1.
    run_frame(4'b1111, 32'hF066_6C36, 1'b0, 4'b0, 4'b0001, 8'h36, 2'd0, 4'd2, 1'b1);
    run_frame(4'b1111, 32'hF066_6C36, 1'b0, 4'b0, 4'b0010, 8'h6C, 2'd1, 4'd2, 1'b1);
    run_frame(4'b1111, 32'hF066_6C36, 1'b0, 4'b0, 4'b0100, 8'h66, 2'd2, 4'd2, 1'b1);
    run_frame(4'b1111, 32'hF066_6C36, 1'b0, 4'b0, 4'b1000, 8'hF0, 2'd3, 4'd0, 1'b1);
    run_frame(4'b1111, 32'hF066_6C36, 1'b0, 4'b0, 4'b0001, 8'h36, 2'd0, 4'd2, 1'b1);
    run_frame(4'b1010, 32'hF066_6C36, 1'b0, 4'b0, 4'b0010, 8'h6C, 2'd1, 4'd2, 1'b1);
    run_frame(4'b1010, 32'hF066_6C36, 1'b0, 4'b0, 4'b1000, 8'hF0, 2'd3, 4'd0, 1'b1);
    run_frame(4'b1010, 32'hF066_6C36, 1'b0, 4'b0, 4'b0010, 8'h6C, 2'd1, 4'd2, 1'b0);

    // cfg_we during SHIFT is rejected with a single cfg_err pulse.
    @(negedge clk);
    req        = 4'b0001;
    frame_data = 32'h0000_0036;
    @(negedge clk);
    req = 4'b0000;
    check("cfgshift_gnt", 32'(gnt), 32'b0001);
    @(negedge clk);
    cfg_we  = 1'b1;
    cfg_pat = 4'b1111;
    @(negedge clk);
    cfg_we = 1'b0;
    check("cfg_err_pulse", 32'(cfg_err), 32'd1);
    @(negedge clk);
    check("cfg_err_one_cycle", 32'(cfg_err), 32'd0);
    repeat (5) @(negedge clk);
    check("cfgshift_done", 32'(done), 32'd1);
    check("cfgshift_cnt", 32'(match_cnt), 32'd2);
    repeat (2) @(negedge clk);
    check("done_pulse_drop", 32'(done), 32'd0);
    check("done_id_hold", 32'(done_id), 32'd0);
    check("match_cnt_hold", 32'(match_cnt), 32'd2);
    run_frame(4'b0001, 32'h0000_0036, 1'b0, 4'b0, 4'b0001, 8'h36, 2'd0, 4'd2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
